// File: rtl/mux16to1_pkg.sv
// mux16to1_pkg: shared sizing for the two-level 16:1 selector tree
package mux16to1_pkg;
  localparam int GROUPS = 4;
  localparam int GW = 4;
  typedef logic [GW-1:0] grp_t;
endpackage

// File: rtl/mux16to1_if.sv
// mux16to1_if: data groups, selects and registered active-low output
interface mux16to1_if;
  logic [3:0] In1;
  logic [7:4] In2;
  logic [11:8] In3;
  logic [15:12] In4;
  logic [1:0] sel1;
  logic [1:0] sel2;
  logic Y_L;
  modport master (output In1, In2, In3, In4, sel1, sel2, input Y_L);
  modport slave (input In1, In2, In3, In4, sel1, sel2, output Y_L);
endinterface

// File: rtl/mux16to1_mux4to1.sv
// mux4to1: combinational 4:1 bit selector; an unknown select yields X rather than a merged value
module mux4to1
  import mux16to1_pkg::*;
(
  input  grp_t       d,
  input  logic [1:0] s,
  output logic       y
);
  assign y = d[s];
endmodule

// File: rtl/mux16to1.sv
// mux16to1: 16:1 selector tree with inverted, registered output
module mux16to1
  import mux16to1_pkg::*;
(
  input logic clk,
  input logic rst,
  mux16to1_if.slave bus
);
  localparam logic Y_L_RST = 1'b1;
  logic [15:0] d;
  logic [GROUPS-1:0] grp;
  logic sel_y;
  logic y_l_d;
  logic y_l_q;
  assign d = {bus.In4, bus.In3, bus.In2, bus.In1};
  for (genvar i = 0; i < GROUPS; i++) begin : g_l1
    mux4to1 u_l1 (.d(d[GW*i +: GW]), .s(bus.sel1), .y(grp[i]));
  end
  mux4to1 u_l2 (.d(grp), .s(bus.sel2), .y(sel_y));
  assign y_l_d = ~sel_y;
  always_ff @(posedge clk) y_l_q <= rst ? Y_L_RST : y_l_d;
  assign bus.Y_L = y_l_q;
endmodule

// File: tb/tb_mux16to1.sv
// tb_mux16to1: directed and random checks of mux16to1 against an arithmetic reference
module tb_mux16to1;
  logic clk;
  logic rst;
  int checks;
  int errors;
  logic exp_q;
  logic [15:0] tbl;
  mux16to1_if bus();
  mux16to1 dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic model(input logic [15:0] dv, input logic [1:0] s1, input logic [1:0] s2);
    int idx;
    idx = 4 * int'(s2) + int'(s1);
    return ((dv >> idx) & 16'd1) == 16'd0;
  endfunction
  task automatic drive(input logic [15:0] dv, input logic [1:0] s1, input logic [1:0] s2);
    bus.In1 = dv[3:0];
    bus.In2 = dv[7:4];
    bus.In3 = dv[11:8];
    bus.In4 = dv[15:12];
    bus.sel1 = s1;
    bus.sel2 = s2;
  endtask
  task automatic tick(input logic r);
    rst = r;
    exp_q = r ? 1'b1 : model({bus.In4, bus.In3, bus.In2, bus.In1}, bus.sel1, bus.sel2);
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic exp);
    checks++;
    assert (bus.Y_L === exp) else begin
      errors++;
      $error("FAIL %s: Y_L=%b expected %b", tag, bus.Y_L, exp);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(16'($urandom), 2'($urandom), 2'($urandom));
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      drive(16'($urandom), 2'($urandom), 2'($urandom));
      tick(1'b1);
      chk("reset", 1'b1);
      @(negedge clk);
    end
    drive(16'hA5C3, 2'd2, 2'd1);
    tick(1'b0);
    chk("release", exp_q);
    chk("release_const", 1'b0);
    tbl = 16'hB4C3;
    for (int s2 = 0; s2 < 4; s2++)
      for (int s1 = 0; s1 < 4; s1++) begin
        @(negedge clk);
        drive(16'h4B3C, 2'(s1), 2'(s2));
        tick(1'b0);
        chk("patA", tbl[4*s2+s1]);
        chk("patA_model", exp_q);
      end
    tbl = 16'h0003;
    for (int s2 = 0; s2 < 4; s2++)
      for (int s1 = 0; s1 < 4; s1++) begin
        @(negedge clk);
        drive(16'hFFFC, 2'(s1), 2'(s2));
        tick(1'b0);
        chk("patB", tbl[4*s2+s1]);
      end
    @(negedge clk);
    drive(16'h0000, 2'd0, 2'd0);
    tick(1'b0);
    chk("lat_before", 1'b1);
    @(negedge clk);
    drive(16'h0001, 2'd0, 2'd0);
    #1;
    chk("lat_not_early", 1'b1);
    @(posedge clk);
    #1;
    chk("lat_after", 1'b0);
    @(negedge clk);
    drive(16'h4B3C, 2'd0, 2'd1);
    tick(1'b0);
    chk("mid_pre", 1'b0);
    @(negedge clk);
    tick(1'b1);
    chk("mid_rst", 1'b1);
    @(negedge clk);
    tick(1'b0);
    chk("mid_post", 1'b0);
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        drive(16'd1 << k, 2'(j % 4), 2'(j / 4));
        tick(1'b0);
        chk("walk", (j == k) ? 1'b0 : 1'b1);
      end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drive(16'($urandom), 2'($urandom), 2'($urandom));
      tick($urandom_range(0, 15) == 0);
      chk("random", exp_q);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
